// File: rtl/gsm_resp_parser.sv
// ---------------------------------------------------------------------------
// gsm_resp_parser
//
// Classifies response lines returned by a GSM modem, one received byte at a
// time, without buffering the line. Recognised lines are "OK", "ERROR",
// the SMS-text prompt "> " and the unsolicited "+CMTI: <mem>,<n>" indication.
// Each classification is reported as a registered one-cycle pulse.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   rx_data   received byte, meaningful only while rx_valid=1
//   rx_valid  one-cycle strobe per byte; there is no backpressure
//   ok_o      pulse: line "OK" terminated
//   err_o     pulse: line "ERROR" terminated
//   prompt_o  pulse: "> " seen at line start
//   cmti_o    pulse: valid +CMTI line terminated (msg_idx updated same cycle)
//   unk_o     pulse: non-empty line matched nothing, or overflowed
//   msg_idx   index from the last valid +CMTI line
//   ovf_o     sticky: a line exceeded MAX_LINE bytes; cleared only by reset
//
// Handshake: a byte is consumed on every rising clk edge where rx_valid=1;
// cycles with rx_valid=0 leave all parser state unchanged. Every pulse is
// asserted for exactly one cycle, the cycle after the accepting edge.
// ---------------------------------------------------------------------------
module gsm_resp_parser #(
  parameter int MAX_LINE = 64,
  parameter int IDX_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             ok_o,
  output logic             err_o,
  output logic             prompt_o,
  output logic             cmti_o,
  output logic             unk_o,
  output logic [IDX_W-1:0] msg_idx,
  output logic             ovf_o
);

  localparam int LEN_W = $clog2(MAX_LINE + 1);

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_GT    = 8'h3E;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  // S_START: nothing but CR seen since the last LF (or prompt / reset).
  // S_LINE : inside a line of at most MAX_LINE bytes.
  // S_SKIP : line overflowed; discarding until LF.
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_LINE  = 2'd1,
    S_SKIP  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len, len_n;
  logic             ok_c, ok_c_n;
  logic             err_c, err_c_n;
  logic             cmti_c, cmti_c_n;
  logic             prompt_c, prompt_c_n;
  logic             comma_seen, comma_seen_n;
  logic             dig_seen, dig_seen_n;
  logic [IDX_W-1:0] acc, acc_n;
  logic [IDX_W+3:0] acc_x10;

  logic             ok_n, err_n, prompt_n, cmti_n, unk_n, ovf_n;
  logic [IDX_W-1:0] msg_idx_n;

  function automatic logic [7:0] ok_char(input int i);
    case (i)
      0:       return 8'h4F; // O
      1:       return 8'h4B; // K
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] err_char(input int i);
    case (i)
      0:       return 8'h45; // E
      1:       return 8'h52; // R
      2:       return 8'h52; // R
      3:       return 8'h4F; // O
      4:       return 8'h52; // R
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] cmti_char(input int i);
    case (i)
      0:       return 8'h2B; // +
      1:       return 8'h43; // C
      2:       return 8'h4D; // M
      3:       return 8'h54; // T
      4:       return 8'h49; // I
      5:       return 8'h3A; // :
      default: return 8'h00;
    endcase
  endfunction

  // acc*10 + digit, computed 4 bits wider so saturation can be detected.
  assign acc_x10 = ({4'b0, acc} << 3) + ({4'b0, acc} << 1)
                 + {{IDX_W{1'b0}}, rx_data[3:0]};

  always_comb begin
    state_n      = state;
    len_n        = len;
    ok_c_n       = ok_c;
    err_c_n      = err_c;
    cmti_c_n     = cmti_c;
    prompt_c_n   = prompt_c;
    comma_seen_n = comma_seen;
    dig_seen_n   = dig_seen;
    acc_n        = acc;
    ok_n         = 1'b0;
    err_n        = 1'b0;
    prompt_n     = 1'b0;
    cmti_n       = 1'b0;
    unk_n        = 1'b0;
    ovf_n        = ovf_o;
    msg_idx_n    = msg_idx;

    if (rx_valid && rx_data != CH_CR) begin
      if (rx_data == CH_LF) begin
        if (state == S_LINE) begin
          if (ok_c && int'(len) == 2) begin
            ok_n = 1'b1;
          end else if (err_c && int'(len) == 5) begin
            err_n = 1'b1;
          end else if (cmti_c && dig_seen) begin
            cmti_n    = 1'b1;
            msg_idx_n = acc;
          end else begin
            unk_n = 1'b1;
          end
        end else if (state == S_SKIP) begin
          unk_n = 1'b1;
        end
        // Back to line start; candidates are re-armed for the next line.
        state_n      = S_START;
        len_n        = '0;
        ok_c_n       = 1'b1;
        err_c_n      = 1'b1;
        cmti_c_n     = 1'b1;
        prompt_c_n   = 1'b0;
        comma_seen_n = 1'b0;
        dig_seen_n   = 1'b0;
        acc_n        = '0;
      end else if (state == S_SKIP) begin
        state_n = S_SKIP;
      end else if (state == S_LINE && len == LEN_W'(MAX_LINE)) begin
        ovf_n   = 1'b1;
        state_n = S_SKIP;
      end else if (state == S_LINE && prompt_c && rx_data == CH_SP) begin
        // "> " is not followed by LF, so re-arm line start right here.
        prompt_n     = 1'b1;
        state_n      = S_START;
        len_n        = '0;
        ok_c_n       = 1'b1;
        err_c_n      = 1'b1;
        cmti_c_n     = 1'b1;
        prompt_c_n   = 1'b0;
        comma_seen_n = 1'b0;
        dig_seen_n   = 1'b0;
        acc_n        = '0;
      end else begin
        // Ordinary line byte: len is also the byte's position in the line.
        ok_c_n     = ok_c && int'(len) < 2 && rx_data == ok_char(int'(len));
        err_c_n    = err_c && int'(len) < 5 && rx_data == err_char(int'(len));
        prompt_c_n = (state == S_START) && rx_data == CH_GT;
        if (int'(len) < 6) begin
          cmti_c_n = cmti_c && rx_data == cmti_char(int'(len));
        end else if (cmti_c) begin
          if (!comma_seen) begin
            if (rx_data == CH_COMMA) comma_seen_n = 1'b1;
          end else if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            dig_seen_n = 1'b1;
            if (acc_x10 > {4'b0, {IDX_W{1'b1}}}) acc_n = '1;
            else                                 acc_n = acc_x10[IDX_W-1:0];
          end else if (rx_data != CH_SP) begin
            cmti_c_n = 1'b0;
          end
        end
        len_n   = len + LEN_W'(1);
        state_n = S_LINE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_START;
      len        <= '0;
      ok_c       <= 1'b1;
      err_c      <= 1'b1;
      cmti_c     <= 1'b1;
      prompt_c   <= 1'b0;
      comma_seen <= 1'b0;
      dig_seen   <= 1'b0;
      acc        <= '0;
      ok_o       <= 1'b0;
      err_o      <= 1'b0;
      prompt_o   <= 1'b0;
      cmti_o     <= 1'b0;
      unk_o      <= 1'b0;
      ovf_o      <= 1'b0;
      msg_idx    <= '0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      ok_c       <= ok_c_n;
      err_c      <= err_c_n;
      cmti_c     <= cmti_c_n;
      prompt_c   <= prompt_c_n;
      comma_seen <= comma_seen_n;
      dig_seen   <= dig_seen_n;
      acc        <= acc_n;
      ok_o       <= ok_n;
      err_o      <= err_n;
      prompt_o   <= prompt_n;
      cmti_o     <= cmti_n;
      unk_o      <= unk_n;
      ovf_o      <= ovf_n;
      msg_idx    <= msg_idx_n;
    end
  end

endmodule

// File: tb/tb_gsm_resp_parser.sv
// ---------------------------------------------------------------------------
// tb_gsm_resp_parser
//
// Drives modem response streams into gsm_resp_parser. A line-level model
// (byte queue per line, classified with string compares when LF arrives)
// pushes expected events {due cycle, pulse vector, msg_idx, ovf} into
// exp_q; an independent monitor pops and compares whenever a pulse appears.
// ---------------------------------------------------------------------------
module tb_gsm_resp_parser;

  localparam int MAX_LINE = 64;
  localparam int IDX_W    = 8;
  localparam int W        = 32 + 5 + IDX_W + 1;

  localparam logic [4:0] EV_OK     = 5'b00001;
  localparam logic [4:0] EV_ERR    = 5'b00010;
  localparam logic [4:0] EV_PROMPT = 5'b00100;
  localparam logic [4:0] EV_CMTI   = 5'b01000;
  localparam logic [4:0] EV_UNK    = 5'b10000;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             ok_o, err_o, prompt_o, cmti_o, unk_o, ovf_o;
  logic [IDX_W-1:0] msg_idx;
  int               cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gsm_resp_parser #(.MAX_LINE(MAX_LINE), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ok_o     (ok_o),
    .err_o    (err_o),
    .prompt_o (prompt_o),
    .cmti_o   (cmti_o),
    .unk_o    (unk_o),
    .msg_idx  (msg_idx),
    .ovf_o    (ovf_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  byte unsigned line_q[$];
  bit           m_skip = 1'b0;
  bit           m_ovf  = 1'b0;
  logic [7:0]   m_idx  = 8'd0;

  // Event becomes visible after the next rising edge: driven at a negedge
  // where cyc=N, the edge makes cyc=N+1 and the monitor sees it then.
  task automatic push_ev(input logic [4:0] ev);
    exp_q.push_back({32'(cyc + 1), ev, m_idx, m_ovf});
  endtask

  task automatic classify();
    string s = "";
    int    comma = -1;
    int    acc   = 0;
    bit    good  = 1'b1;
    bit    dig   = 1'b0;
    foreach (line_q[i]) s = $sformatf("%s%c", s, line_q[i]);
    if (s == "OK") begin
      push_ev(EV_OK);
    end else if (s == "ERROR") begin
      push_ev(EV_ERR);
    end else if (s.len() >= 6 && s.substr(0, 5) == "+CMTI:") begin
      for (int i = 6; i < s.len(); i++) begin
        if (s[i] == 8'h2C) begin
          comma = i;
          break;
        end
      end
      if (comma < 0) begin
        good = 1'b0;
      end else begin
        for (int i = comma + 1; i < s.len(); i++) begin
          if (s[i] >= 8'h30 && s[i] <= 8'h39) begin
            acc = acc * 10 + (int'(s[i]) - 48);
            if (acc > 255) acc = 255;
            dig = 1'b1;
          end else if (s[i] != 8'h20) begin
            good = 1'b0;
          end
        end
      end
      if (good && dig) begin
        m_idx = 8'(acc);
        push_ev(EV_CMTI);
      end else begin
        push_ev(EV_UNK);
      end
    end else begin
      push_ev(EV_UNK);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0D) return;
    if (b == 8'h0A) begin
      if (m_skip) push_ev(EV_UNK);
      else if (line_q.size() > 0) classify();
      line_q.delete();
      m_skip = 1'b0;
      return;
    end
    if (m_skip) return;
    if (line_q.size() == 1 && line_q[0] == 8'h3E && b == 8'h20) begin
      push_ev(EV_PROMPT);
      line_q.delete();
      return;
    end
    if (line_q.size() == MAX_LINE) begin
      m_skip = 1'b1;
      m_ovf  = 1'b1;
      line_q.delete();
      return;
    end
    line_q.push_back(b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      idle(gap);
    end
  endtask

  // Random gaps and stray CRs inside the line.
  task automatic send_rand(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if ($urandom_range(0, 9) == 0) send(8'h0D);
      send(s[i]);
      idle($urandom_range(0, 2));
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  logic [4:0]   mon_pulses;

  always @(negedge clk) begin
    mon_pulses = {unk_o, cmti_o, prompt_o, err_o, ok_o};
    while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) < cyc) begin
      n_checks++;
      $display("FAIL missing_event: expected %0h not seen by cycle %0d", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    if (mon_pulses != 5'b0) begin
      mon_got = {32'(cyc), mon_pulses, msg_idx, ovf_o};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got %0h with none expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, 64'({ok_o, err_o, prompt_o, cmti_o, unk_o}), 64'd0);
    check({tag, "_msg_idx"}, 64'(msg_idx), 64'd0);
    check({tag, "_ovf"}, 64'(ovf_o), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  string alpha = "OKER+CMTI:,0129 >A\"S";
  string s;

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Leading empty line then OK, back-to-back.
    send(8'h0D); send(8'h0A); send(8'h4F); send(8'h4B); send(8'h0D); send(8'h0A);
    idle(3);

    send_str("\r\nERROR\r\n", 3);
    send_str("OKX\r\n", 0);
    idle(2);

    send_str("\r\n+CMTI: \"SM\",12\r\n", 0);
    send_str("+CMTI: \"SM\",999\r\n", 1);
    send_str("+CMTI: \"SM\",\r\n", 0);
    idle(2);

    send(8'h3E); send(8'h20);
    send_str("OK\r\n", 0);
    idle(2);

    // Overflow: 64 bytes keep ovf clear, the 65th sets it.
    for (int i = 0; i < 64; i++) send(8'h41);
    idle(1);
    check("ovf_at_64", 64'(ovf_o), 64'(m_ovf));
    send(8'h41);
    idle(1);
    check("ovf_at_65", 64'(ovf_o), 64'(m_ovf));
    send(8'h0D); send(8'h0A);
    idle(2);
    for (int i = 0; i < 64; i++) send(8'h41);
    send(8'h0D); send(8'h0A);
    send_str("OK\r\n", 0);
    idle(3);

    // Randomized response stream.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: s = "OK\r\n";
        1: s = "ERROR\r\n";
        2: s = $sformatf("+CMTI: \"SM\",%0d\r\n", $urandom_range(0, 2000));
        3: s = $sformatf("+CMTI: \"ME\", %0d \r\n", $urandom_range(0, 99));
        4: s = "> ";
        5: begin
          s = "";
          for (int i = 0; i < $urandom_range(1, 70); i++)
            s = $sformatf("%s%c", s, alpha[$urandom_range(0, alpha.len() - 1)]);
          s = {s, "\r\n"};
        end
        6: case ($urandom_range(0, 4))
             0: s = "OKK\r\n";
             1: s = "ERRO\r\n";
             2: s = "+CMTI\r\n";
             3: s = "+CMTI: \"SM\",1a\r\n";
             default: s = "ok\r\n";
           endcase
        default: s = "\r\n";
      endcase
      send_rand(s);
    end
    send_str("\r\n", 0);
    idle(4);

    // Asynchronous reset in the middle of a line.
    send_str("+CMT", 0);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    check_all_zero("async_reset");
    line_q.delete();
    m_skip = 1'b0;
    m_ovf  = 1'b0;
    m_idx  = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_str("I: \"SM\",3\r\n", 0);
    idle(5);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_msg_idx", 64'(msg_idx), 64'(m_idx));
    check("final_ovf", 64'(ovf_o), 64'(m_ovf));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
